// File: rtl/mem_port_ram.sv
// mem_port_ram: multi-port word RAM with byte-strobed writes, pipelined reads,
// out-of-range flag and saturating access counters.
module mem_port_ram #(
  parameter int NR = 3,
  parameter int NW = 1,
  parameter int AXI_WIDTH = 128,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4096,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR-1:0]             rd_ren,
  input  logic [NR*ADDR_W-1:0]      rd_addr,
  output logic [NR*AXI_WIDTH-1:0]   rd_data,
  output logic [NR-1:0]             rd_valid,
  input  logic [NW-1:0]             wr_wen,
  input  logic [NW*ADDR_W-1:0]      wr_addr,
  input  logic [NW*AXI_WIDTH-1:0]   wr_data,
  input  logic [NW*AXI_WIDTH/8-1:0] wr_strb,
  output logic                      err_oob,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count
);
  localparam int BY = AXI_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  logic [AXI_WIDTH-1:0] mem [DEPTH];
  logic [NR-1:0] rd_ok;
  logic [NW-1:0] wr_ok, wr_hit;
  logic [3:0] rd_inc, wr_inc;
  logic oob;
  function automatic logic [31:0] sat(input logic [31:0] c, input logic [3:0] n);
    logic [32:0] s;
    s = {1'b0, c} + 33'(n);
    return s[32] ? '1 : s[31:0];
  endfunction
  always_comb begin
    rd_ok = '0;
    wr_ok = '0;
    wr_hit = '0;
    rd_inc = '0;
    wr_inc = '0;
    oob = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rd_ok[i] = {1'b0, rd_addr[i*ADDR_W +: ADDR_W]} < LIM;
      rd_inc = rd_inc + 4'(rd_ren[i] & rd_ok[i]);
      oob = oob | (rd_ren[i] & ~rd_ok[i]);
    end
    for (int i = 0; i < NW; i++) begin
      wr_ok[i] = {1'b0, wr_addr[i*ADDR_W +: ADDR_W]} < LIM;
      wr_hit[i] = wr_wen[i] & wr_ok[i];
      wr_inc = wr_inc + 4'(wr_hit[i] & (|wr_strb[i*BY +: BY]));
      oob = oob | (wr_wen[i] & ~wr_ok[i]);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      err_oob <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      err_oob <= err_oob | oob;
      rd_count <= sat(rd_count, rd_inc);
      wr_count <= sat(wr_count, wr_inc);
    end
  // Ascending port order lets the highest-index port win each contested byte.
  always_ff @(posedge clk)
    if (!rst)
      for (int w = 0; w < NW; w++)
        for (int b = 0; b < BY; b++)
          if (wr_hit[w] && wr_strb[w*BY + b])
            mem[wr_addr[w*ADDR_W +: IW]][b*8 +: 8] <= wr_data[w*AXI_WIDTH + b*8 +: 8];
  for (genvar r = 0; r < NR; r++) begin : g_rd
    logic [AXI_WIDTH-1:0] word;
    assign word = rd_ok[r] ? mem[rd_addr[r*ADDR_W +: IW]] : '0;
    for (genvar s = 0; s < RD_LAT; s++) begin : g_st
      logic v, vi;
      logic [AXI_WIDTH-1:0] d, di;
      if (s == 0) begin : g_h
        assign vi = rd_ren[r];
        assign di = word;
      end else begin : g_t
        assign vi = g_st[s-1].v;
        assign di = g_st[s-1].d;
      end
      // The last stage is the output register and only loads on a valid read.
      always_ff @(posedge clk)
        if (rst) begin
          v <= 1'b0;
          d <= '0;
        end else begin
          v <= vi;
          if (s < RD_LAT - 1 || vi) d <= di;
        end
    end
    assign rd_valid[r] = g_st[RD_LAT-1].v;
    assign rd_data[r*AXI_WIDTH +: AXI_WIDTH] = g_st[RD_LAT-1].d;
  end
endmodule

// File: tb/tb_mem_port_ram.sv
// tb_mem_port_ram: directed vectors plus randomized traffic checked against a
// queue-based reference model of the RAM.
module tb_mem_port_ram;
  localparam int NR = 3, NW = 2, W = 128, AW = 16, D = 4096, L = 3, BY = W / 8;
  localparam logic [W-1:0] P = 128'h0F0E0D0C0B0A09080706050403020100;
  logic clk = 1'b0, rst = 1'b1;
  logic [NR-1:0] ren, rvalid;
  logic [NR*AW-1:0] raddr;
  logic [NR*W-1:0] rdata;
  logic [NW-1:0] wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*W-1:0] wdata;
  logic [NW*BY-1:0] wstrb;
  logic err;
  logic [31:0] rcnt, wcnt;

  mem_port_ram #(.NR(NR), .NW(NW), .AXI_WIDTH(W), .ADDR_W(AW), .DEPTH(D), .RD_LAT(L)) dut (
    .clk(clk), .rst(rst), .rd_ren(ren), .rd_addr(raddr), .rd_data(rdata), .rd_valid(rvalid),
    .wr_wen(wen), .wr_addr(waddr), .wr_data(wdata), .wr_strb(wstrb),
    .err_oob(err), .rd_count(rcnt), .wr_count(wcnt)
  );

  always #5 clk = ~clk;

  typedef struct {int p; int due; logic [W-1:0] d;} rq_t;
  typedef struct {int a; logic [W-1:0] wd; logic [BY-1:0] s; logic [W-1:0] exp; int winc;} vec_t;
  rq_t q[$];
  logic [W-1:0] mdl [D];
  logic [W-1:0] mlast [NR];
  logic [NR-1:0] mv;
  longint mrd, mwr;
  logic merr;
  int cyc, checks, fails;
  vec_t vt [6];

  function automatic logic [W-1:0] fill(int a);
    return {16{8'(a * 3 + 1)}};
  endfunction

  task automatic chk(string nm, logic [W-1:0] a, logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  // Reference model: reads snapshot the array before writes, results queue with a due edge.
  task automatic model();
    mv = '0;
    if (rst) begin
      q.delete();
      mrd = 0;
      mwr = 0;
      merr = 1'b0;
      foreach (mlast[i]) mlast[i] = '0;
    end else begin
      for (int p = 0; p < NR; p++)
        if (ren[p]) begin
          int a;
          rq_t e;
          a = int'(raddr[p*AW +: AW]);
          e.p = p;
          e.due = cyc + L - 1;
          e.d = '0;
          if (a >= D) merr = 1'b1;
          else begin
            mrd++;
            e.d = mdl[a];
          end
          q.push_back(e);
        end
      for (int w = 0; w < NW; w++)
        if (wen[w]) begin
          int a;
          a = int'(waddr[w*AW +: AW]);
          if (a >= D) merr = 1'b1;
          else begin
            if (wstrb[w*BY +: BY] != '0) mwr++;
            for (int b = 0; b < BY; b++)
              if (wstrb[w*BY + b]) mdl[a][b*8 +: 8] = wdata[w*W + b*8 +: 8];
          end
        end
    end
    while (q.size() > 0 && q[0].due == cyc) begin
      mv[q[0].p] = 1'b1;
      mlast[q[0].p] = q[0].d;
      void'(q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model();
    #1;
    chk("rd_valid", W'(rvalid), W'(mv));
    for (int p = 0; p < NR; p++) chk($sformatf("rd_data%0d", p), rdata[p*W +: W], mlast[p]);
    chk("err_oob", W'(err), W'(merr));
    chk("rd_count", W'(rcnt), W'(mrd > 64'hFFFFFFFF ? 64'hFFFFFFFF : mrd));
    chk("wr_count", W'(wcnt), W'(mwr > 64'hFFFFFFFF ? 64'hFFFFFFFF : mwr));
  endtask

  task automatic idle();
    ren = '0;
    wen = '0;
    wstrb = '0;
  endtask

  task automatic wr(int w, int a, logic [W-1:0] d, logic [BY-1:0] s);
    wen[w] = 1'b1;
    waddr[w*AW +: AW] = AW'(a);
    wdata[w*W +: W] = d;
    wstrb[w*BY +: BY] = s;
  endtask

  task automatic rd(int p, int a);
    ren[p] = 1'b1;
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic drain();
    idle();
    repeat (L - 1) tick();
  endtask

  initial begin
    int c_r, c_w, first, n;
    cyc = 0;
    checks = 0;
    fails = 0;
    idle();
    raddr = '0;
    waddr = '0;
    wdata = '0;
    vt[0] = '{7, {16{8'hAA}}, 16'hFFFF, {16{8'hAA}}, 1};
    vt[1] = '{7, {16{8'h55}}, 16'h00FF, {{8{8'hAA}}, {8{8'h55}}}, 1};
    vt[2] = '{7, {16{8'h33}}, 16'h0000, {{8{8'hAA}}, {8{8'h55}}}, 0};
    vt[3] = '{9, {16{8'hC3}}, 16'hFFFF, {16{8'hC3}}, 1};
    vt[4] = '{9, {16{8'h3C}}, 16'h8001, {8'h3C, {14{8'hC3}}, 8'h3C}, 1};
    vt[5] = '{12, {16{8'hAB}}, 16'h8000, {8'hAB, {15{8'h25}}}, 1};
    repeat (2) tick();
    chk("reset_valid", W'(rvalid), '0);
    chk("reset_data0", rdata[0 +: W], '0);
    chk("reset_counts", W'({rcnt, wcnt, 31'd0, err}), '0);
    rst = 1'b0;
    for (int a = 0; a < 64; a++) begin
      wr(0, a, fill(a), '1);
      tick();
    end
    wr(0, 904, fill(904), '1);
    tick();
    idle();
    chk("prefill_wr_count", W'(wcnt), W'(65));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(0, 5, P, '1);
    tick();
    idle();
    for (int p = 0; p < NR; p++) rd(p, 5);
    tick();
    drain();
    chk("bcast_valid", W'(rvalid), W'(3'b111));
    for (int p = 0; p < NR; p++) chk($sformatf("bcast_data%0d", p), rdata[p*W +: W], P);
    chk("bcast_wr_count", W'(wcnt), W'(1));
    chk("bcast_rd_count", W'(rcnt), W'(3));
    for (int i = 0; i < 6; i++) begin
      c_w = int'(wcnt);
      wr(0, vt[i].a, vt[i].wd, vt[i].s);
      tick();
      idle();
      chk($sformatf("vec%0d_winc", i), W'(int'(wcnt) - c_w), W'(vt[i].winc));
      rd(0, vt[i].a);
      tick();
      drain();
      chk($sformatf("vec%0d_valid", i), W'(rvalid[0]), W'(1));
      chk($sformatf("vec%0d_data", i), rdata[0 +: W], vt[i].exp);
    end
    c_w = int'(wcnt);
    wr(0, 40, {16{8'h11}}, 16'hFFFF);
    wr(1, 40, {16{8'h22}}, 16'h0F0F);
    rd(2, 40);
    tick();
    drain();
    chk("coll_old", rdata[2*W +: W], fill(40));
    chk("coll_winc", W'(int'(wcnt) - c_w), W'(2));
    rd(2, 40);
    tick();
    drain();
    chk("coll_new", rdata[2*W +: W], {32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222});
    first = -1;
    n = 0;
    for (int k = 0; k < 16 + L; k++) begin
      idle();
      if (k < 16) rd(1, 16 + k);
      tick();
      if (rvalid[1]) begin
        if (first < 0) first = k;
        chk("stream_nogap", W'(k - first), W'(n));
        chk("stream_data", rdata[W +: W], fill(16 + n));
        n++;
      end
    end
    idle();
    chk("stream_first", W'(first), W'(L - 1));
    chk("stream_count", W'(n), W'(16));
    chk("oob_err_pre", W'(err), '0);
    c_r = int'(rcnt);
    c_w = int'(wcnt);
    rd(0, 4096);
    tick();
    idle();
    chk("oob_err_rise", W'(err), W'(1));
    repeat (L - 1) tick();
    chk("oob_rd_valid", W'(rvalid[0]), W'(1));
    chk("oob_rd_data", rdata[0 +: W], '0);
    wr(0, 5000, {16{8'hEE}}, '1);
    tick();
    idle();
    chk("oob_err_sticky", W'(err), W'(1));
    chk("oob_rd_count", W'(rcnt), W'(c_r));
    chk("oob_wr_count", W'(wcnt), W'(c_w));
    rd(0, 904);
    tick();
    drain();
    chk("oob_mem_intact", rdata[0 +: W], fill(904));
    for (int p = 0; p < NR; p++) rd(p, 10);
    tick();
    idle();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < L + 2; k++) begin
      tick();
      chk("rst_no_valid", W'(rvalid), '0);
    end
    chk("rst_data_zero", W'(rdata), '0);
    chk("rst_err_zero", W'(err), '0);
    chk("rst_counts_zero", W'({rcnt, wcnt}), '0);
    rd(0, 5);
    tick();
    drain();
    chk("rst_mem_intact", rdata[0 +: W], P);
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(99) == 0);
      for (int p = 0; p < NR; p++) begin
        ren[p] = 1'($urandom_range(1));
        raddr[p*AW +: AW] = ($urandom_range(15) == 0) ? AW'(D + $urandom_range(100)) : AW'($urandom_range(63));
      end
      for (int w = 0; w < NW; w++) begin
        wen[w] = ($urandom_range(3) == 0);
        waddr[w*AW +: AW] = ($urandom_range(15) == 0) ? AW'(D + $urandom_range(1000)) : AW'($urandom_range(63));
        wdata[w*W +: W] = {$urandom, $urandom, $urandom, $urandom};
        wstrb[w*BY +: BY] = ($urandom_range(7) == 0) ? '0 : BY'($urandom);
      end
      tick();
    end
    idle();
    rst = 1'b0;
    repeat (L) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
